// File: rtl/nco_pkg.sv
// Shared constants for the NCO/mixer: accumulator width, reset tuning word, dither LFSR.
// The dither LFSR is only built when NCO_DITHER_EN is defined.
package nco_pkg;

  localparam int PHASE_W  = 26;
  localparam int LFSR_W   = 16;
  localparam int DITHER_W = 4;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [LFSR_W-1:0]  lfsr_t;

  localparam phase_t DEFAULT_INC = 26'h1312EB;
  localparam lfsr_t  LFSR_SEED   = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam lfsr_t  LFSR_TAPS   = 16'hB400;

  function automatic lfsr_t lfsr_next(input lfsr_t state);
    lfsr_t shifted;
    shifted = {1'b0, state[LFSR_W-1:1]};
    if (state[0]) begin
      lfsr_next = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Galois LFSR producing the low-order phase dither word.
// Instantiated by nco_mixer only when NCO_DITHER_EN is defined.
module nco_lfsr
  import nco_pkg::*;
(
  input  logic                CLK,
  input  logic                RSTb,
  output logic [DITHER_W-1:0] dither
);

  lfsr_t lfsr_r;

  // LFSR state register, advances once per clock
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign dither = lfsr_r[DITHER_W-1:0];

endmodule

// File: rtl/nco_mixer.sv
// Phase-accumulator NCO with wrap-synchronous retuning and a 1-bit quadrature mixer.
// Define NCO_DITHER_EN to add LFSR dither to the accumulator.
module nco_mixer
  import nco_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTb,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               RF_IN,
  output logic [PHASE_W-1:0] phase,
  output logic               lo_i,
  output logic               lo_q,
  output logic               mix_i,
  output logic               mix_q,
  output logic               wrap,
  output logic               upd_pending
);

  phase_t              phase_r;
  phase_t              active_inc_r;
  phase_t              shadow_r;
  phase_t              pending_inc_r;
  logic                upd_pending_r;
  logic                wrap_r;
  logic                rf_meta_r;
  logic                rf_s_r;
  logic                mix_i_r;
  logic                mix_q_r;
  logic [DITHER_W-1:0] dither_s;
  logic [PHASE_W:0]    sum_s;
  logic                carry_s;
  logic                change_s;
  logic                apply_s;
  logic                lo_i_s;
  logic                lo_q_s;

`ifdef NCO_DITHER_EN
  nco_lfsr u_lfsr (
    .CLK    (CLK),
    .RSTb   (RSTb),
    .dither (dither_s)
  );
`else
  assign dither_s = {DITHER_W{1'b0}};
`endif

  // Next-phase sum and retune decisions; a zero active increment never wraps,
  // so a pending word is applied immediately in that case.
  always_comb begin
    sum_s    = {1'b0, phase_r} + {1'b0, active_inc_r}
             + {{(PHASE_W + 1 - DITHER_W){1'b0}}, dither_s};
    carry_s  = sum_s[PHASE_W];
    change_s = (phase_inc != shadow_r);
    apply_s  = upd_pending_r & (carry_s | (active_inc_r == {PHASE_W{1'b0}}));
  end

  // Phase accumulator and wrap pulse
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      phase_r <= {PHASE_W{1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      phase_r <= sum_s[PHASE_W-1:0];
      wrap_r  <= carry_s;
    end
  end

  // Tuning word capture; a change wins over a coincident apply for upd_pending
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      active_inc_r  <= DEFAULT_INC;
      shadow_r      <= DEFAULT_INC;
      pending_inc_r <= DEFAULT_INC;
      upd_pending_r <= 1'b0;
    end else begin
      if (apply_s) begin
        active_inc_r <= pending_inc_r;
      end
      if (change_s) begin
        shadow_r      <= phase_inc;
        pending_inc_r <= phase_inc;
        upd_pending_r <= 1'b1;
      end else if (apply_s) begin
        upd_pending_r <= 1'b0;
      end
    end
  end

  // Square-wave quadrature LO decoded from the top two phase bits
  always_comb begin
    lo_i_s = ~(phase_r[PHASE_W-1] ^ phase_r[PHASE_W-2]);
    lo_q_s = ~phase_r[PHASE_W-1];
  end

  // RF synchroniser and registered XNOR mixer
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rf_meta_r <= 1'b0;
      rf_s_r    <= 1'b0;
      mix_i_r   <= 1'b0;
      mix_q_r   <= 1'b0;
    end else begin
      rf_meta_r <= RF_IN;
      rf_s_r    <= rf_meta_r;
      mix_i_r   <= ~(rf_s_r ^ lo_i_s);
      mix_q_r   <= ~(rf_s_r ^ lo_q_s);
    end
  end

  assign phase       = phase_r;
  assign lo_i        = lo_i_s;
  assign lo_q        = lo_q_s;
  assign mix_i       = mix_i_r;
  assign mix_q       = mix_q_r;
  assign wrap        = wrap_r;
  assign upd_pending = upd_pending_r;

endmodule

// File: tb/tb_nco_mixer.sv
// Self-checking bench for nco_mixer against a cycle-level arithmetic reference model.
module tb_nco_mixer;

  localparam logic [25:0] DEF_INC = 26'h1312EB;

  logic        CLK  = 1'b0;
  logic        RSTb = 1'b1;
  logic        RF_IN = 1'b0;
  logic [25:0] phase_inc = DEF_INC;
  logic [25:0] phase;
  logic        lo_i, lo_q, mix_i, mix_q, wrap, upd_pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [25:0] m_phase, m_active, m_shadow, m_pending;
  logic        m_upd, m_wrap, m_mix_i, m_mix_q;
  logic [1:0]  m_rf;
  logic [15:0] m_lfsr;

  wire [31:0] dut_vec = {phase, wrap, upd_pending, mix_i, mix_q, lo_i, lo_q};

  always #5 CLK = ~CLK;

  nco_mixer u_dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .phase_inc   (phase_inc),
    .RF_IN       (RF_IN),
    .phase       (phase),
    .lo_i        (lo_i),
    .lo_q        (lo_q),
    .mix_i       (mix_i),
    .mix_q       (mix_q),
    .wrap        (wrap),
    .upd_pending (upd_pending)
  );

  function automatic logic [3:0] m_dither();
`ifdef NCO_DITHER_EN
    return m_lfsr[3:0];
`else
    return 4'd0;
`endif
  endfunction

  function automatic logic [31:0] m_vec();
    return {m_phase, m_wrap, m_upd, m_mix_i, m_mix_q,
            ~(m_phase[25] ^ m_phase[24]), ~m_phase[25]};
  endfunction

  function automatic logic m_carry_next();
    logic [26:0] s;
    s = {1'b0, m_phase} + {1'b0, m_active} + {23'd0, m_dither()};
    return s[26];
  endfunction

  task automatic model_reset();
    m_phase = 26'd0; m_active = DEF_INC; m_shadow = DEF_INC; m_pending = DEF_INC;
    m_upd = 1'b0; m_wrap = 1'b0; m_mix_i = 1'b0; m_mix_q = 1'b0;
    m_rf = 2'b00; m_lfsr = 16'hACE1;
  endtask

  // one clock of the specified behaviour, evaluated on the inputs seen at the edge
  task automatic model_step();
    logic [26:0] s;
    logic        carry, apply, li, lq, lsb;
    s     = {1'b0, m_phase} + {1'b0, m_active} + {23'd0, m_dither()};
    carry = s[26];
    apply = m_upd && (carry || (m_active == 26'd0));
    li    = ~(m_phase[25] ^ m_phase[24]);
    lq    = ~m_phase[25];
    m_mix_i = (m_rf[1] == li);
    m_mix_q = (m_rf[1] == lq);
    m_rf    = {m_rf[0], RF_IN};
    if (apply) m_active = m_pending;
    if (phase_inc != m_shadow) begin
      m_shadow = phase_inc; m_pending = phase_inc; m_upd = 1'b1;
    end else if (apply) begin
      m_upd = 1'b0;
    end
    m_wrap  = carry;
    m_phase = s[25:0];
    lsb     = m_lfsr[0];
    m_lfsr  = m_lfsr >> 1;
    if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTb = 1'b0; phase_inc = DEF_INC; RF_IN = 1'b0;
    @(posedge CLK);
    #1;
    RSTb = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 RSTb = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec, {26'd0, 6'b000011});
    end
    do_reset();
  endtask

  task automatic test_default();
    for (int i = 0; i < 10; i++) begin
      RF_IN = 1'($urandom);
      tick();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL default_vec cyc %0d got %h exp %h", i, dut_vec, m_vec());
      end
    end
`ifndef NCO_DITHER_EN
    checks++;
    if (phase !== 26'hBEBD2E) begin
      errors++; $display("FAIL default_phase10 got %h exp %h", phase, 26'hBEBD2E);
    end
`endif
    checks++;
    if (upd_pending !== 1'b0) begin
      errors++; $display("FAIL default_upd got %b exp 0", upd_pending);
    end
  endtask

  task automatic test_retune_wrap();
    logic        seen;
    logic [25:0] prev;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      RF_IN = 1'($urandom);
      tick();
    end
    phase_inc = 26'h2000000;
    tick();
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++; $display("FAIL retune_upd_set got %b exp 1", upd_pending);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      RF_IN = 1'($urandom);
      tick();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL retune_vec got %h exp %h", dut_vec, m_vec());
      end
      if (wrap) seen = 1'b1;
    end
    checks++;
    if (!seen || upd_pending !== 1'b0) begin
      errors++; $display("FAIL retune_applied got wrap_seen=%b upd=%b exp wrap_seen=1 upd=0", seen, upd_pending);
    end
`ifndef NCO_DITHER_EN
    for (int i = 0; i < 3; i++) begin
      prev = m_phase;
      tick();
      checks++;
      if (phase !== prev + 26'h2000000) begin
        errors++; $display("FAIL retune_delta got %h exp %h", phase, prev + 26'h2000000);
      end
    end
`endif
  endtask

  task automatic test_last_write();
    logic        seen;
    logic [25:0] prev;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    phase_inc = 26'h100;
    tick();
    phase_inc = 26'h200;
    tick();
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++; $display("FAIL lastwr_upd got %b exp 1", upd_pending);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL lastwr_vec got %h exp %h", dut_vec, m_vec());
      end
      if (wrap) seen = 1'b1;
    end
    checks++;
    if (!seen || upd_pending !== 1'b0) begin
      errors++; $display("FAIL lastwr_applied got wrap_seen=%b upd=%b exp wrap_seen=1 upd=0", seen, upd_pending);
    end
`ifndef NCO_DITHER_EN
    for (int i = 0; i < 3; i++) begin
      prev = m_phase;
      tick();
      checks++;
      if (phase !== prev + 26'h200) begin
        errors++; $display("FAIL lastwr_delta got %h exp %h", phase, prev + 26'h200);
      end
    end
`endif
  endtask

  task automatic test_coincident();
    logic        found, seen;
    logic [25:0] prev;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_carry_next()) begin
        phase_inc = 26'h1000000;
        tick();
        checks++;
        if (upd_pending !== 1'b1 || wrap !== 1'b1) begin
          errors++; $display("FAIL coinc_keep got upd=%b wrap=%b exp upd=1 wrap=1", upd_pending, wrap);
        end
        found = 1'b1;
      end else begin
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coinc_timeout got no carry exp carry within 100 cycles");
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL coinc_vec got %h exp %h", dut_vec, m_vec());
      end
      if (wrap) seen = 1'b1;
    end
    checks++;
    if (!seen || upd_pending !== 1'b0) begin
      errors++; $display("FAIL coinc_applied got wrap_seen=%b upd=%b exp wrap_seen=1 upd=0", seen, upd_pending);
    end
`ifndef NCO_DITHER_EN
    prev = m_phase;
    tick();
    checks++;
    if (phase !== prev + 26'h1000000) begin
      errors++; $display("FAIL coinc_delta got %h exp %h", phase, prev + 26'h1000000);
    end
`endif
  endtask

  task automatic test_deadlock_quad();
    logic       seen;
    logic [1:0] lo_tab [4];
    int         wraps;
    lo_tab[0] = 2'b11; lo_tab[1] = 2'b01; lo_tab[2] = 2'b00; lo_tab[3] = 2'b10;
    do_reset();
    phase_inc = 26'd0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (wrap) seen = 1'b1;
    end
    checks++;
    if (!seen || upd_pending !== 1'b0) begin
      errors++; $display("FAIL zero_applied got wrap_seen=%b upd=%b exp wrap_seen=1 upd=0", seen, upd_pending);
    end
    phase_inc = 26'h1000000;
    tick();
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++; $display("FAIL deadlock_upd_set got %b exp 1", upd_pending);
    end
    tick();
    checks++;
    if (upd_pending !== 1'b0) begin
      errors++; $display("FAIL deadlock_apply got %b exp 0", upd_pending);
    end
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      RF_IN = 1'($urandom);
      tick();
      checks++;
      if ({lo_i, lo_q} !== lo_tab[m_phase[25:24]] || dut_vec !== m_vec()) begin
        errors++; $display("FAIL quad_lo got lo=%b%b vec=%h exp lo=%b vec=%h",
                           lo_i, lo_q, dut_vec, lo_tab[m_phase[25:24]], m_vec());
      end
`ifndef NCO_DITHER_EN
      checks++;
      if (wrap !== (m_phase[25:24] == 2'b00)) begin
        errors++; $display("FAIL quad_wrap got %b exp %b", wrap, (m_phase[25:24] == 2'b00));
      end
`endif
      if (wrap) wraps++;
    end
`ifndef NCO_DITHER_EN
    checks++;
    if (wraps != 3) begin
      errors++; $display("FAIL quad_wrap_count got %0d exp 3", wraps);
    end
`endif
  endtask

  task automatic test_mixer();
    logic pli, plq;
    for (int pass = 0; pass < 2; pass++) begin
      RF_IN = (pass == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 6; i++) begin
        pli = ~(m_phase[25] ^ m_phase[24]);
        plq = ~m_phase[25];
        tick();
        checks++;
        if (mix_i !== (RF_IN ? pli : ~pli) || mix_q !== (RF_IN ? plq : ~plq)) begin
          errors++; $display("FAIL mixer rf=%b got %b%b exp %b%b", RF_IN, mix_i, mix_q,
                             RF_IN ? pli : ~pli, RF_IN ? plq : ~plq);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      RF_IN = 1'($urandom);
      tick();
    end
    phase_inc = 26'h2000000;
    tick();
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++; $display("FAIL rstmid_upd_set got %b exp 1", upd_pending);
    end
    #3 RSTb = 1'b0;
    phase_inc = DEF_INC;
    RF_IN = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rstmid_state got %h exp %h", dut_vec, {26'd0, 6'b000011});
    end
    #1 RSTb = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec !== m_vec() || upd_pending !== 1'b0) begin
        errors++; $display("FAIL rstmid_after got %h exp %h", dut_vec, m_vec());
      end
    end
`ifndef NCO_DITHER_EN
    checks++;
    if (phase !== 26'h4C4BAC) begin
      errors++; $display("FAIL rstmid_phase got %h exp %h", phase, 26'h4C4BAC);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default();
    test_retune_wrap();
    test_last_write();
    test_coincident();
    test_deadlock_quad();
    test_mixer();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
